// File: rtl/fir_delay_line_param.sv
// fir_delay_line_param
// Parametrised FIR input delay line with a registered tap-select read port,
// per-tap valid flag, fill tracking and a sequential zero-flush.
// tap[0] holds the newest sample and tap[DEPTH-1] the oldest.
// A flush shifts zeros through the line for exactly DEPTH cycles.
// During a flush the old samples leave on oChain, oldest first.
module fir_delay_line_param #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 10,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEnDelay,
  input  logic [DATA_W-1:0] iFirIn,
  input  logic              iFlush,
  input  logic [SEL_W-1:0]  iInSel,
  output logic [DATA_W-1:0] oTap_Mux,
  output logic              oTapVld,
  output logic [DATA_W-1:0] oChain,
  output logic              oPrimed,
  output logic              oBusy,
  output logic [CNT_W-1:0]  oFillCnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tap_q [DEPTH];
  logic [DATA_W-1:0] tap_d [DEPTH];
  logic [CNT_W-1:0]  fillCnt_q, fillCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
  logic [DATA_W-1:0] tapMux_q, tapMux_d;
  logic              tapVld_q, tapVld_d;
  logic              doShift;
  logic [DATA_W-1:0] shiftIn;

  // Control: flush beats a same-cycle shift strobe, and a flush always runs DEPTH shifts.
  always_comb begin
    state_d    = state_q;
    fillCnt_d  = fillCnt_q;
    flushCnt_d = flushCnt_q;
    doShift    = 1'b0;
    shiftIn    = '0;
    case (state_q)
      IDLE: begin
        if (iFlush) begin
          state_d    = FLUSH;
          flushCnt_d = CNT_W'(DEPTH);
          fillCnt_d  = '0;
        end else if (iEnDelay) begin
          doShift = 1'b1;
          shiftIn = iFirIn;
          if (fillCnt_q != CNT_W'(DEPTH)) begin
            fillCnt_d = fillCnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        doShift    = 1'b1;
        flushCnt_d = flushCnt_q - CNT_W'(1);
        if (flushCnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next tap contents: either hold, or move every sample one tap older.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      tap_d[k] = tap_q[k];
    end
    if (doShift) begin
      tap_d[0] = shiftIn;
      for (int k = 1; k < DEPTH; k++) begin
        tap_d[k] = tap_q[k-1];
      end
    end
  end

  // Read port: the select is decoded explicitly, so an out-of-range index reads zero instead of X.
  always_comb begin
    tapMux_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(iInSel) == k) begin
        tapMux_d = tap_q[k];
      end
    end
    tapVld_d = (int'(iInSel) < int'(fillCnt_q));
  end

  // State, taps, counters and the registered read port all update together.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      fillCnt_q  <= '0;
      flushCnt_q <= '0;
      tapMux_q   <= '0;
      tapVld_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fillCnt_q  <= fillCnt_d;
      flushCnt_q <= flushCnt_d;
      tapMux_q   <= tapMux_d;
      tapVld_q   <= tapVld_d;
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= tap_d[k];
      end
    end
  end

  assign oTap_Mux = tapMux_q;
  assign oTapVld  = tapVld_q;
  assign oChain   = tap_q[DEPTH-1];
  assign oPrimed  = (fillCnt_q == CNT_W'(DEPTH));
  assign oBusy    = (state_q == FLUSH);
  assign oFillCnt = fillCnt_q;

endmodule

// File: tb/tb_fir_delay_line_param.sv
// tb_fir_delay_line_param
// Self-checking bench for the parametrised FIR delay line.
// It starts with table-driven vectors and hand-written flush and reset sequences.
// It then runs a randomised phase against a queue-based reference model.
module tb_fir_delay_line_param;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 10;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iEnDelay;
  logic [DATA_W-1:0] iFirIn;
  logic              iFlush;
  logic [SEL_W-1:0]  iInSel;
  logic [DATA_W-1:0] oTap_Mux;
  logic              oTapVld;
  logic [DATA_W-1:0] oChain;
  logic              oPrimed;
  logic              oBusy;
  logic [CNT_W-1:0]  oFillCnt;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    bit en;
    int din;
    int sel;
    int expMux;
    int expVld;
    int expFill;
  } vec_t;

  vec_t vecs [8];

  // Reference model state.
  // The queue front is the newest sample.
  int mLine[$];
  int mFill;
  int mFlushLeft;
  int mMux;
  int mVld;

  fir_delay_line_param #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEnDelay(iEnDelay),
    .iFirIn  (iFirIn),
    .iFlush  (iFlush),
    .iInSel  (iInSel),
    .oTap_Mux(oTap_Mux),
    .oTapVld (oTapVld),
    .oChain  (oChain),
    .oPrimed (oPrimed),
    .oBusy   (oBusy),
    .oFillCnt(oFillCnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    testsRun++;
    if (actual !== 32'(expected)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, take the rising edge, then settle 1 unit past it.
  task automatic applyStimulus(input bit en, input bit flush, input int din, input int sel);
    iEnDelay = en;
    iFlush   = flush;
    iFirIn   = DATA_W'(din);
    iInSel   = SEL_W'(sel);
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iRst     = 1'b1;
    iEnDelay = 1'b0;
    iFlush   = 1'b0;
    iFirIn   = '0;
    iInSel   = '0;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic modelReset();
    mLine.delete();
    for (int k = 0; k < DEPTH; k++) mLine.push_back(0);
    mFill      = 0;
    mFlushLeft = 0;
    mMux       = 0;
    mVld       = 0;
  endtask

  // One clock edge of the model: the read port sees the pre-edge line, then the line moves.
  task automatic modelStep(input bit en, input bit flush, input int din, input int sel);
    mMux = (sel < DEPTH) ? mLine[sel] : 0;
    mVld = (sel < mFill) ? 1 : 0;
    if (mFlushLeft > 0) begin
      mLine.push_front(0);
      void'(mLine.pop_back());
      mFlushLeft--;
    end else if (flush) begin
      mFlushLeft = DEPTH;
      mFill      = 0;
    end else if (en) begin
      mLine.push_front(din);
      void'(mLine.pop_back());
      mFill = (mFill + 1 > DEPTH) ? DEPTH : mFill + 1;
    end
  endtask

  initial begin
    int seq[10];
    int busyCount;

    seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

    // Partial fill with 5, 6, 7, then reads including in-range, unfilled and out-of-range taps.
    vecs[0] = '{en: 1'b1, din: 5, sel: 0,  expMux: 0, expVld: 0, expFill: 1};
    vecs[1] = '{en: 1'b1, din: 6, sel: 0,  expMux: 5, expVld: 1, expFill: 2};
    vecs[2] = '{en: 1'b1, din: 7, sel: 1,  expMux: 5, expVld: 1, expFill: 3};
    vecs[3] = '{en: 1'b0, din: 0, sel: 2,  expMux: 5, expVld: 1, expFill: 3};
    vecs[4] = '{en: 1'b0, din: 0, sel: 3,  expMux: 0, expVld: 0, expFill: 3};
    vecs[5] = '{en: 1'b0, din: 0, sel: 0,  expMux: 7, expVld: 1, expFill: 3};
    vecs[6] = '{en: 1'b0, din: 0, sel: 12, expMux: 0, expVld: 0, expFill: 3};
    vecs[7] = '{en: 1'b0, din: 0, sel: 15, expMux: 0, expVld: 0, expFill: 3};

    doReset();
    checkOutput("reset chain",  oChain,   0);
    checkOutput("reset primed", oPrimed,  0);
    checkOutput("reset busy",   oBusy,    0);
    checkOutput("reset fill",   oFillCnt, 0);
    checkOutput("reset mux",    oTap_Mux, 0);
    checkOutput("reset vld",    oTapVld,  0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en, 1'b0, vecs[i].din, vecs[i].sel);
      checkOutput($sformatf("vec%0d mux", i),  oTap_Mux, vecs[i].expMux);
      checkOutput($sformatf("vec%0d vld", i),  oTapVld,  vecs[i].expVld);
      checkOutput($sformatf("vec%0d fill", i), oFillCnt, vecs[i].expFill);
      checkOutput($sformatf("vec%0d primed", i), oPrimed, 0);
    end

    // Full line: ten strobes, oldest sample at the chain output.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, seq[i], 0);
    checkOutput("full chain",  oChain,   1);
    checkOutput("full primed", oPrimed,  1);
    checkOutput("full fill",   oFillCnt, 10);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("full sel0 mux", oTap_Mux, 2);
    checkOutput("full sel0 vld", oTapVld,  1);
    applyStimulus(1'b0, 1'b0, 0, 9);
    checkOutput("full sel9 mux", oTap_Mux, 1);
    checkOutput("full sel9 vld", oTapVld,  1);
    applyStimulus(1'b0, 1'b0, 0, 12);
    checkOutput("full sel12 mux", oTap_Mux, 0);
    checkOutput("full sel12 vld", oTapVld,  0);
    applyStimulus(1'b0, 1'b0, 0, 15);
    checkOutput("full sel15 mux", oTap_Mux, 0);
    checkOutput("full sel15 vld", oTapVld,  0);

    // Flush with the shift strobe held high: samples leave oldest first.
    applyStimulus(1'b1, 1'b1, 3, 0);
    checkOutput("flush entry busy", oBusy,    1);
    checkOutput("flush entry fill", oFillCnt, 0);
    busyCount = 0;
    for (int c = 0; c < 20 && oBusy; c++) begin
      if (busyCount < 10) checkOutput($sformatf("flush chain%0d", busyCount), oChain, seq[busyCount]);
      checkOutput("flush fill", oFillCnt, 0);
      busyCount++;
      applyStimulus(1'b1, 1'b0, 5, 0);
    end
    checkOutput("flush busy cycles", busyCount, 10);
    checkOutput("post flush busy",  oBusy,    0);
    checkOutput("post flush fill",  oFillCnt, 0);
    checkOutput("post flush chain", oChain,   0);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b0, 1'b0, 0, k);
      checkOutput($sformatf("post flush tap%0d", k), oTap_Mux, 0);
      checkOutput($sformatf("post flush vld%0d", k), oTapVld,  0);
    end
    applyStimulus(1'b1, 1'b0, 4, 0);
    checkOutput("post flush accept fill", oFillCnt, 1);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("post flush accept mux", oTap_Mux, 4);
    checkOutput("post flush accept vld", oTapVld,  1);

    // Flush and strobe on the same edge: the sample 6 is dropped.
    applyStimulus(1'b1, 1'b1, 6, 0);
    checkOutput("drop busy", oBusy,    1);
    checkOutput("drop fill", oFillCnt, 0);
    busyCount = 0;
    for (int c = 0; c < 20 && oBusy; c++) begin
      checkOutput($sformatf("drop chain%0d", busyCount), oChain, (busyCount == 9) ? 4 : 0);
      busyCount++;
      applyStimulus(1'b0, 1'b0, 0, 0);
    end
    checkOutput("drop busy cycles", busyCount, 10);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b0, 1'b0, 0, k);
      checkOutput($sformatf("drop tap%0d", k), oTap_Mux, 0);
    end

    // Asynchronous reset four cycles into a flush.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, i + 1, 0);
    applyStimulus(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("pre-reset busy", oBusy, 1);
    #2;
    iRst = 1'b1;
    #1;
    checkOutput("async rst busy",  oBusy,    0);
    checkOutput("async rst fill",  oFillCnt, 0);
    checkOutput("async rst chain", oChain,   0);
    checkOutput("async rst mux",   oTap_Mux, 0);
    checkOutput("async rst vld",   oTapVld,  0);
    checkOutput("async rst primed", oPrimed, 0);
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    applyStimulus(1'b1, 1'b0, 7, 0);
    checkOutput("resume busy", oBusy,    0);
    checkOutput("resume fill", oFillCnt, 1);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("resume mux", oTap_Mux, 7);
    checkOutput("resume vld", oTapVld,  1);

    // Randomised phase against the reference model.
    doReset();
    modelReset();
    for (int i = 0; i < 600; i++) begin
      bit en;
      bit fl;
      int din;
      int sel;
      en  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      din = int'($urandom_range(0, (1 << DATA_W) - 1));
      sel = int'($urandom_range(0, (1 << SEL_W) - 1));
      modelStep(en, fl, din, sel);
      applyStimulus(en, fl, din, sel);
      checkOutput($sformatf("rnd%0d mux", i),    oTap_Mux, mMux);
      checkOutput($sformatf("rnd%0d vld", i),    oTapVld,  mVld);
      checkOutput($sformatf("rnd%0d chain", i),  oChain,   mLine[DEPTH-1]);
      checkOutput($sformatf("rnd%0d fill", i),   oFillCnt, mFill);
      checkOutput($sformatf("rnd%0d primed", i), oPrimed,  (mFill == DEPTH) ? 1 : 0);
      checkOutput($sformatf("rnd%0d busy", i),   oBusy,    (mFlushLeft > 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
